control_multicycle: RTL
=======================

# control_multicycle

Multicycle main control unit for the MIPS core. A registered Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back. It drives the shared-ALU/shared-memory datapath strobes, and stalls on a memory-ready handshake. It traps illegal opcodes and counts retired instructions. It supersedes the single-cycle opcode decoder and keeps the same `branch` bit convention: BRANCH_BEQ = bit 0, BRANCH_BNE = bit 1.

## Interface
- `MEM_HANDSHAKE`, default 1: when 1, memory states wait for `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `TRAP_EN`, default 1: when 1, an illegal opcode enters TRAP; when 0, it returns to FETCH as a no-op.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`, input, 1: the block's single clock.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `opcode`, input, 6: IR[31:26]; stable from DECODE onward.
- `mem_ready`, input, 1: memory has completed the current read/write this cycle.
- `pcwrite`, `irwrite`, `memread`, `memwrite`, `regwrite`, output, 1 each: datapath strobes.
- `iord`, `alusrca`, `regdst`, `memtoreg`, output, 1 each: mux selects.
- `alusrcb`, output, 2: 00 = reg B, 01 = +4, 10 = sign-ext imm, 11 = imm<<2.
- `aluop`, output, 2: 00 = add, 01 = sub, 10 = funct.
- `pcsource`, output, 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `branch`, output, 2: conditional PC-write enables, [0] = beq, [1] = bne.
- `state`, output, 4: current state, for debug.
- `retired`, output, 1: one-cycle pulse in the final cycle of each instruction.
- `instr_count`, output, CNT_W: retired-instruction count; wraps modulo 2^CNT_W.
- `trap`, output, 1: high while in TRAP.

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - j 000010
  - addi 001000
  - all others are illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTYPEWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12. Codes 13–15 are unreachable and recover to FETCH.
- Transitions:
  - FETCH to DECODE when ready.
  - DECODE goes by opcode:
    - lw or sw → MEMADR
    - R-type → EXEC
    - beq or bne → BRANCH
    - j → JUMP
    - addi → ADDIEX
    - illegal → TRAP, or FETCH when `TRAP_EN` = 0.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB when ready.
  - MEMWR → FETCH when ready.
  - EXEC → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BRANCH and JUMP → FETCH.
  - TRAP holds until reset.
- Outputs per state (any output not listed is 0):
  - FETCH: memread, alusrcb = 01. irwrite and pcwrite assert only when ready.
  - DECODE: alusrcb = 11.
  - MEMADR and ADDIEX: alusrca, alusrcb = 10.
  - MEMRD: memread, iord.
  - MEMWR: memwrite, iord.
  - MEMWB: regwrite, memtoreg.
  - EXEC: alusrca, aluop = 10.
  - RTYPEWB: regwrite, regdst.
  - ADDIWB: regwrite.
  - BRANCH: alusrca, aluop = 01, pcsource = 01. `branch[opcode[0]]` = 1.
  - JUMP: pcwrite, pcsource = 10.
- `retired` asserts in MEMWB, RTYPEWB, ADDIWB, BRANCH and JUMP, and in MEMWR only when ready. `instr_count` increments by 1 on the same clock edge.
- An illegal opcode never pulses `retired`.

## Timing
- Outputs are a combinational decode of the registered `state`, plus `mem_ready` in the gated cases. There is no output register.
- Zero-wait latencies: lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3.
- Each low `mem_ready` cycle in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted while waiting.
- Reset, which may occur mid-instruction:
  - `state` is forced to FETCH and `instr_count` to 0.
  - While `reset_n` = 0, every strobe (`pcwrite`, `irwrite`, `memread`, `memwrite`, `regwrite`, `branch`) and `retired` and `trap` are 0.
  - Selects take their FETCH values.
- FETCH begins on the first rising edge after `reset_n` rises.
- `instr_count` wraps from all-ones to 0 on the next retire, with no flag.

## Structure
- `control_pkg` holds:
  - the state encoding constants
  - the opcode constants
  - the `alusrcb`, `aluop` and `pcsource` codes
  - `BRANCH_BEQ` / `BRANCH_BNE`.
- One sub-module, `control_outdec`: a purely combinational decode of state, opcode and ready into datapath signals.
- The top level holds the state register, next-state logic and the counter.

## Test plan
- Zero-wait lw (100011): states 0→1→2→3→4→0 over 5 cycles. One `retired` pulse; `instr_count` 0→1. Strobes match the per-state list.
- beq (000100) then bne (000101): `branch` = 01, then 10, each in its third cycle. `pcsource` = 01 and `aluop` = 01.
- sw with `mem_ready` low for 3 cycles in MEMWR: 7 cycles total. `memwrite` and `iord` are held throughout. `retired` pulses only in the ready cycle.
- Opcode 111111 with `TRAP_EN` = 1: TRAP (12), `trap` = 1, held for 20 cycles, no retire. With `TRAP_EN` = 0: DECODE→FETCH, no retire.
- `reset_n` asserted mid-MEMRD: all strobes drop asynchronously, `state` = 0 and `instr_count` = 0. After release, the first FETCH asserts `memread`.
- `CNT_W` = 4 with 17 back-to-back j instructions (3 cycles each): `instr_count` wraps 15→0 and ends at 1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
package control_pkg;

    // FSM state codes; 13..15 are unused and fall back to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    // Opcodes from IR[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU B-operand select.
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Bit positions within the conditional PC-write enable vector.
    localparam int BRANCH_BEQ = 0;
    localparam int BRANCH_BNE = 1;

    // Everything the output decoder drives toward the datapath.
    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic [1:0] branch;
        logic       retired;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/control_outdec.sv
// Moore output decode: state (plus ready for the gated strobes) to datapath controls.
module control_outdec
    import control_pkg::*;
(
    input  state_e st,
    input  logic   branch_sel,   // opcode[0]: 0 = beq, 1 = bne
    input  logic   ready,
    input  logic   run,          // low while reset is held
    output ctrl_t  ctrl
);

    // Per-state strobes and selects; reset forces all strobes low but keeps FETCH selects.
    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = ready;
                ctrl.pcwrite = ready;
            end
            S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.retired  = ready;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.retired  = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.retired  = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.retired  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca  = 1'b1;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsource = PCSRC_ALUOUT;
                ctrl.branch[branch_sel ? BRANCH_BNE : BRANCH_BEQ] = 1'b1;
                ctrl.retired  = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
                ctrl.retired  = 1'b1;
            end
            S_TRAP: ctrl.trap = 1'b1;
            default: ;
        endcase

        if (!run) begin
            ctrl.pcwrite  = 1'b0;
            ctrl.irwrite  = 1'b0;
            ctrl.memread  = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.regwrite = 1'b0;
            ctrl.branch   = 2'b00;
            ctrl.retired  = 1'b0;
            ctrl.trap     = 1'b0;
        end
    end

endmodule

// File: rtl/control_multicycle.sv
// Multicycle MIPS main control: state register, next-state logic, retire counter.
module control_multicycle
    import control_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_EN       = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic             alusrca,
    output logic             regdst,
    output logic             memtoreg,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic [1:0]       branch,
    output logic [3:0]       state,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             ready;
    ctrl_t            ctrl;

    // Without the handshake, memory is assumed to finish in one cycle.
    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state: memory states hold until ready, DECODE dispatches on opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDIEX;
                    default:        state_d = TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (ready) state_d = S_MEMWB;
            S_MEMWR:   if (ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          count_q <= '0;
        else if (ctrl.retired) count_q <= count_q + CNT_W'(1);
    end

    control_outdec u_outdec (
        .st        (state_q),
        .branch_sel(opcode[0]),
        .ready     (ready),
        .run       (reset_n),
        .ctrl      (ctrl)
    );

    assign pcwrite     = ctrl.pcwrite;
    assign irwrite     = ctrl.irwrite;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign regwrite    = ctrl.regwrite;
    assign iord        = ctrl.iord;
    assign alusrca     = ctrl.alusrca;
    assign regdst      = ctrl.regdst;
    assign memtoreg    = ctrl.memtoreg;
    assign alusrcb     = ctrl.alusrcb;
    assign aluop       = ctrl.aluop;
    assign pcsource    = ctrl.pcsource;
    assign branch      = ctrl.branch;
    assign retired     = ctrl.retired;
    assign trap        = ctrl.trap;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule
